pc_sequencer: RTL and testbench

- Consumer end of the jump/control group interface: owns the program counter, the HERE operand pointer, the instruction register and the fetch/decode/execute/commit phase machine.
- Resolves the decoder-driven PC_BASEX / PC_OFFSETX / ADDR_BUSX selects into a next-PC value and a memory address.
- Issues instruction and operand reads with a ready handshake, and emits the phase strobes that every group decoder consumes.

---
 rtl/pc_sequencer_pkg.sv | 30 +++
 rtl/pc_sequencer_next_calc.sv | 54 +++++
 rtl/pc_sequencer.sv | 142 ++++++++++++++
 tb/tb_pc_sequencer.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/pc_sequencer_pkg.sv
// pc_sequencer_pkg
//   Shared constants for the program-counter sequencer: phase encodings,
//   next-PC base/offset select codes, memory address select codes and the
//   default reset vector. Imported by pc_sequencer and pc_next_calc.
package pc_sequencer_pkg;

  localparam int          AW_DEFAULT           = 16;
  localparam logic [15:0] RESET_VECTOR_DEFAULT = 16'h0000;

  typedef enum logic [1:0] {
    PHASE_FETCH   = 2'd0,
    PHASE_DECODE  = 2'd1,
    PHASE_EXECUTE = 2'd2,
    PHASE_COMMIT  = 2'd3
  } phase_t;

  localparam logic [1:0] PC_BASEX_ZERO = 2'd0;
  localparam logic [1:0] PC_BASEX_PC   = 2'd1;
  localparam logic [1:0] PC_BASEX_REGB = 2'd2;
  localparam logic [1:0] PC_BASEX_RSVD = 2'd3;

  localparam logic [1:0] PC_OFFSETX_ZERO    = 2'd0;
  localparam logic [1:0] PC_OFFSETX_TWO     = 2'd1;
  localparam logic [1:0] PC_OFFSETX_FOUR    = 2'd2;
  localparam logic [1:0] PC_OFFSETX_OPERAND = 2'd3;

  localparam logic [1:0] ADDR_BUSX_PC   = 2'd0;
  localparam logic [1:0] ADDR_BUSX_HERE = 2'd1;

endpackage

// File: rtl/pc_sequencer_next_calc.sv
// pc_next_calc
//   Combinational next-PC generator: selects a base and an offset and adds
//   them modulo 2^AW. Also produces the matching HERE pointer (next PC + 2).
// Ports:
//   base_sel    next-PC base select (zero / PC_A / REGB_DOUT / reserved=zero)
//   offset_sel  next-PC offset select (zero / 2 / 4 / OPERAND)
//   pc_a        address of the current instruction
//   regb        register-file port B data
//   operand     latched inline operand
//   next_pc     base + offset
//   next_here   next_pc + 2
module pc_next_calc
  import pc_sequencer_pkg::*;
#(
  parameter int AW = AW_DEFAULT
) (
  input  logic [1:0]    base_sel,
  input  logic [1:0]    offset_sel,
  input  logic [AW-1:0] pc_a,
  input  logic [AW-1:0] regb,
  input  logic [AW-1:0] operand,
  output logic [AW-1:0] next_pc,
  output logic [AW-1:0] next_here
);

  logic [AW-1:0] base;
  logic [AW-1:0] offset;

  // Base mux; the reserved code falls back to zero.
  always_comb begin
    base = '0;
    case (base_sel)
      PC_BASEX_PC:   base = pc_a;
      PC_BASEX_REGB: base = regb;
      default:       base = '0;
    endcase
  end

  // Offset mux; skips (2/4) and relative jumps (OPERAND) share one adder.
  always_comb begin
    offset = '0;
    case (offset_sel)
      PC_OFFSETX_TWO:     offset = AW'(2);
      PC_OFFSETX_FOUR:    offset = AW'(4);
      PC_OFFSETX_OPERAND: offset = operand;
      default:            offset = '0;
    endcase
  end

  // Sums are AW bits wide, so carries out of the top bit simply wrap.
  assign next_pc   = base + offset;
  assign next_here = next_pc + AW'(2);

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer
//   Owns the program counter, the HERE operand pointer, the instruction
//   register and the FETCH/DECODE/EXECUTE/COMMIT phase machine. Issues
//   instruction and operand reads with a MEM_RDY handshake and drives the
//   one-hot phase strobes consumed by the group decoders.
// Ports:
//   CLK, RESET            clock, asynchronous active-high reset
//   HALT                  hold in FETCH without issuing a read
//   PC_BASEX, PC_OFFSETX  next-PC selects (sampled in COMMIT)
//   ADDR_BUSX             memory address select (EXECUTE/COMMIT)
//   RDX                   operand read request (EXECUTE)
//   REGB_DOUT             register-file port B data
//   DATA_IN, MEM_RDY      memory read data and completion
//   ADDR, RD              memory address and read strobe
//   INSTR, OPERAND        latched instruction word and inline operand
//   PC_A, HERE            current instruction address and PC_A+2
//   FETCH..COMMIT         one-hot phase strobes
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter int          AW           = AW_DEFAULT,
  parameter logic [AW-1:0] RESET_VECTOR = AW'(RESET_VECTOR_DEFAULT)
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          HALT,
  input  logic [1:0]    PC_BASEX,
  input  logic [1:0]    PC_OFFSETX,
  input  logic [1:0]    ADDR_BUSX,
  input  logic          RDX,
  input  logic [AW-1:0] REGB_DOUT,
  input  logic [AW-1:0] DATA_IN,
  input  logic          MEM_RDY,
  output logic [AW-1:0] ADDR,
  output logic          RD,
  output logic [15:0]   INSTR,
  output logic [AW-1:0] OPERAND,
  output logic [AW-1:0] PC_A,
  output logic [AW-1:0] HERE,
  output logic          FETCH,
  output logic          DECODE,
  output logic          EXECUTE,
  output logic          COMMIT
);

  phase_t        state;
  phase_t        next_state;
  logic          load_instr;
  logic          load_operand;
  logic [AW-1:0] bus_addr;
  logic [AW-1:0] next_pc;
  logic [AW-1:0] next_here;

  pc_next_calc #(.AW(AW)) u_next_calc (
    .base_sel   (PC_BASEX),
    .offset_sel (PC_OFFSETX),
    .pc_a       (PC_A),
    .regb       (REGB_DOUT),
    .operand    (OPERAND),
    .next_pc    (next_pc),
    .next_here  (next_here)
  );

  // Decoder-selected address for the operand/data phases; reserved codes
  // fall back to PC_A.
  always_comb begin
    bus_addr = PC_A;
    case (ADDR_BUSX)
      ADDR_BUSX_HERE: bus_addr = HERE;
      default:        bus_addr = PC_A;
    endcase
  end

  // Phase register and architectural state. Reset abandons any read in
  // flight because nothing latches until the handshake completes.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state   <= PHASE_FETCH;
      PC_A    <= RESET_VECTOR;
      HERE    <= RESET_VECTOR + AW'(2);
      INSTR   <= '0;
      OPERAND <= '0;
    end else begin
      state <= next_state;
      if (load_instr) begin
        INSTR <= 16'(DATA_IN);
      end
      if (load_operand) begin
        OPERAND <= DATA_IN;
      end
      if (state == PHASE_COMMIT) begin
        PC_A <= next_pc;
        HERE <= next_here;
      end
    end
  end

  // Next phase, read strobe and address. HALT overrides MEM_RDY in FETCH so
  // a halted core never latches a stale instruction.
  always_comb begin
    next_state   = state;
    RD           = 1'b0;
    ADDR         = PC_A;
    load_instr   = 1'b0;
    load_operand = 1'b0;
    case (state)
      PHASE_FETCH: begin
        RD = ~HALT;
        if (!HALT && MEM_RDY) begin
          load_instr = 1'b1;
          next_state = PHASE_DECODE;
        end
      end
      PHASE_DECODE: begin
        next_state = PHASE_EXECUTE;
      end
      PHASE_EXECUTE: begin
        RD   = RDX;
        ADDR = bus_addr;
        if (!RDX) begin
          next_state = PHASE_COMMIT;
        end else if (MEM_RDY) begin
          load_operand = 1'b1;
          next_state   = PHASE_COMMIT;
        end
      end
      PHASE_COMMIT: begin
        ADDR       = bus_addr;
        next_state = PHASE_FETCH;
      end
      default: begin
        next_state = PHASE_FETCH;
      end
    endcase
  end

  assign FETCH   = (state == PHASE_FETCH);
  assign DECODE  = (state == PHASE_DECODE);
  assign EXECUTE = (state == PHASE_EXECUTE);
  assign COMMIT  = (state == PHASE_COMMIT);

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer
//   Directed bench for pc_sequencer: reset state, fetch latch, operand reads
//   with wait states, register and relative jumps with wrap-around, skips,
//   reserved selects, HALT hold and reset in the middle of an operand read.
module tb_pc_sequencer;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        HALT;
  logic [1:0]  PC_BASEX;
  logic [1:0]  PC_OFFSETX;
  logic [1:0]  ADDR_BUSX;
  logic        RDX;
  logic [15:0] REGB_DOUT;
  logic [15:0] DATA_IN;
  logic        MEM_RDY;
  logic [15:0] ADDR;
  logic        RD;
  logic [15:0] INSTR;
  logic [15:0] OPERAND;
  logic [15:0] PC_A;
  logic [15:0] HERE;
  logic        FETCH;
  logic        DECODE;
  logic        EXECUTE;
  logic        COMMIT;

  int total = 0;
  int bad   = 0;
  logic [15:0] curPc;
  logic [15:0] expOperand;

  pc_sequencer dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .HALT       (HALT),
    .PC_BASEX   (PC_BASEX),
    .PC_OFFSETX (PC_OFFSETX),
    .ADDR_BUSX  (ADDR_BUSX),
    .RDX        (RDX),
    .REGB_DOUT  (REGB_DOUT),
    .DATA_IN    (DATA_IN),
    .MEM_RDY    (MEM_RDY),
    .ADDR       (ADDR),
    .RD         (RD),
    .INSTR      (INSTR),
    .OPERAND    (OPERAND),
    .PC_A       (PC_A),
    .HERE       (HERE),
    .FETCH      (FETCH),
    .DECODE     (DECODE),
    .EXECUTE    (EXECUTE),
    .COMMIT     (COMMIT)
  );

  always #5 CLK = ~CLK;

  // Strobes packed as {FETCH,DECODE,EXECUTE,COMMIT}: 8/4/2/1.
  function automatic logic [15:0] strobes();
    return {12'h000, FETCH, DECODE, EXECUTE, COMMIT};
  endfunction

  task automatic checkOutput(input string tag, input logic [15:0] observed,
                             input logic [15:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic halt, input logic memRdy,
                               input logic [15:0] dataIn, input logic rdx,
                               input logic [1:0] busx, input logic [1:0] base,
                               input logic [1:0] off, input logic [15:0] regb);
    HALT       = halt;
    MEM_RDY    = memRdy;
    DATA_IN    = dataIn;
    RDX        = rdx;
    ADDR_BUSX  = busx;
    PC_BASEX   = base;
    PC_OFFSETX = off;
    REGB_DOUT  = regb;
  endtask

  task automatic clockStep();
    @(posedge CLK);
    #2;
  endtask

  // One full instruction from FETCH back to FETCH with no wait states.
  task automatic runInstr(input logic [15:0] word, input logic rdx,
                          input logic [1:0] busx, input logic [1:0] base,
                          input logic [1:0] off, input logic [15:0] regb,
                          input logic [15:0] opData, input logic [15:0] expAddr,
                          input logic [15:0] expPc);
    applyStimulus(1'b0, 1'b1, word, 1'b0, 2'd0, 2'd0, 2'd0, 16'h0000);
    #1;
    checkOutput("fetch addr", ADDR, curPc);
    clockStep();
    checkOutput("decode phase", strobes(), 16'h0004);
    checkOutput("instr latch", INSTR, word);
    checkOutput("decode rd", {15'h0, RD}, 16'h0000);
    clockStep();
    checkOutput("execute phase", strobes(), 16'h0002);
    applyStimulus(1'b0, 1'b1, opData, rdx, busx, 2'd0, 2'd0, 16'h0000);
    #1;
    checkOutput("execute addr", ADDR, expAddr);
    checkOutput("execute rd", {15'h0, RD}, {15'h0, rdx});
    clockStep();
    checkOutput("commit phase", strobes(), 16'h0001);
    if (rdx) expOperand = opData;
    checkOutput("operand", OPERAND, expOperand);
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0, busx, base, off, regb);
    clockStep();
    checkOutput("back to fetch", strobes(), 16'h0008);
    checkOutput("pc_a", PC_A, expPc);
    checkOutput("here", HERE, expPc + 16'd2);
    curPc = expPc;
  endtask

  // JP Rb with offset zero: loads PC_A from REGB_DOUT.
  task automatic setPc(input logic [15:0] value);
    runInstr(16'h0001, 1'b0, 2'd0, 2'd2, 2'd0, value, 16'h0000, curPc, value);
  endtask

  initial begin
    curPc      = 16'h0000;
    expOperand = 16'h0000;
    RESET      = 1'b1;
    applyStimulus(1'b0, 1'b1, 16'hA5A5, 1'b0, 2'd0, 2'd0, 2'd0, 16'h0000);
    #12;
    checkOutput("reset strobes", strobes(), 16'h0008);
    checkOutput("reset addr", ADDR, 16'h0000);
    checkOutput("reset rd", {15'h0, RD}, 16'h0001);
    checkOutput("reset pc_a", PC_A, 16'h0000);
    checkOutput("reset here", HERE, 16'h0002);
    checkOutput("reset instr", INSTR, 16'h0000);
    checkOutput("reset operand", OPERAND, 16'h0000);
    RESET = 1'b0;

    $display("[TB] reset vector, skip by 2");
    runInstr(16'hA5A5, 1'b0, 2'd0, 2'd1, 2'd1, 16'h0000, 16'h0000, 16'h0000, 16'h0002);

    $display("[TB] JP S16 with three wait states");
    setPc(16'h0010);
    applyStimulus(1'b0, 1'b1, 16'h2000, 1'b0, 2'd0, 2'd0, 2'd0, 16'h0000);
    clockStep();
    checkOutput("jp decode", strobes(), 16'h0004);
    clockStep();
    applyStimulus(1'b0, 1'b0, 16'hDEAD, 1'b1, 2'd1, 2'd0, 2'd0, 16'h0000);
    #1;
    checkOutput("jp exec addr", ADDR, 16'h0012);
    checkOutput("jp exec rd", {15'h0, RD}, 16'h0001);
    for (int i = 0; i < 3; i++) begin
      clockStep();
      checkOutput("jp wait phase", strobes(), 16'h0002);
      checkOutput("jp wait addr", ADDR, 16'h0012);
      checkOutput("jp wait operand", OPERAND, 16'h0000);
    end
    applyStimulus(1'b0, 1'b1, 16'h1234, 1'b1, 2'd1, 2'd0, 2'd0, 16'h0000);
    clockStep();
    checkOutput("jp commit phase", strobes(), 16'h0001);
    checkOutput("jp operand", OPERAND, 16'h1234);
    expOperand = 16'h1234;
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0, 2'd1, 2'd0, 2'd3, 16'h0000);
    #1;
    checkOutput("jp commit addr", ADDR, 16'h0012);
    checkOutput("jp commit rd", {15'h0, RD}, 16'h0000);
    clockStep();
    checkOutput("jp pc_a", PC_A, 16'h1234);
    checkOutput("jp here", HERE, 16'h1236);
    curPc = 16'h1234;

    $display("[TB] JR wrap-around");
    setPc(16'hFFF0);
    runInstr(16'h3000, 1'b1, 2'd1, 2'd1, 2'd3, 16'h0000, 16'h0020, 16'hFFF2, 16'h0010);

    $display("[TB] JP Rb");
    runInstr(16'h4001, 1'b0, 2'd0, 2'd2, 2'd0, 16'h4000, 16'h0000, 16'h0010, 16'h4000);

    $display("[TB] non-taken JP S16");
    setPc(16'h0100);
    runInstr(16'h5000, 1'b0, 2'd0, 2'd1, 2'd2, 16'h0000, 16'h0000, 16'h0100, 16'h0104);

    $display("[TB] reserved selects");
    runInstr(16'h5555, 1'b0, 2'd2, 2'd3, 2'd1, 16'h7777, 16'h0000, 16'h0104, 16'h0002);

    $display("[TB] HERE wrap");
    setPc(16'hFFFE);

    $display("[TB] HALT hold");
    applyStimulus(1'b1, 1'b1, 16'hFFFF, 1'b0, 2'd0, 2'd0, 2'd0, 16'h0000);
    #1;
    checkOutput("halt rd", {15'h0, RD}, 16'h0000);
    for (int i = 0; i < 5; i++) begin
      clockStep();
      checkOutput("halt phase", strobes(), 16'h0008);
      checkOutput("halt instr", INSTR, 16'h0001);
      checkOutput("halt rd held", {15'h0, RD}, 16'h0000);
    end
    HALT = 1'b0;
    #1;
    checkOutput("unhalt rd", {15'h0, RD}, 16'h0001);

    $display("[TB] reset during operand wait");
    applyStimulus(1'b0, 1'b1, 16'h6000, 1'b0, 2'd0, 2'd0, 2'd0, 16'h0000);
    clockStep();
    clockStep();
    applyStimulus(1'b0, 1'b0, 16'hBEEF, 1'b1, 2'd1, 2'd0, 2'd0, 16'h0000);
    clockStep();
    checkOutput("wait before reset", strobes(), 16'h0002);
    RESET = 1'b1;
    #1;
    checkOutput("mid reset strobes", strobes(), 16'h0008);
    checkOutput("mid reset pc_a", PC_A, 16'h0000);
    checkOutput("mid reset here", HERE, 16'h0002);
    checkOutput("mid reset operand", OPERAND, 16'h0000);
    checkOutput("mid reset instr", INSTR, 16'h0000);
    RESET = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
